neuron_mac_seq: RTL and testbench
=================================

# neuron_mac_seq

Sequencer that computes one neuron output by driving a single shared 4-bit two's-complement fixed-point multiplier (Q2.2 in, Q2.2 out: product bits [5:2]) over N_INPUTS input/weight pairs. It fetches operand pairs from synchronous-read input and weight memories and accumulates the products on top of a bias. It then applies ReLU and saturates the sum to Q2.2. Sits between the layer controller (start/done handshake) and the multiplier/memories in the digit-detection datapath.

## Interface
- N_INPUTS, default 16: number of input/weight pairs per neuron (≥1).
- ADDR_W, default 4: memory address width, ≥ clog2(N_INPUTS).
- ACC_W, default 12: signed accumulator width, Q(ACC_W-2).2. Must be ≥ 4+clog2(N_INPUTS+1), so the accumulator never wraps.

Ports:
- clk  in  1  single clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a neuron computation; sampled only in IDLE.
- bias  in  4  signed Q2.2 bias, captured on the accepting edge.
- busy  out  1  high from accept until the DONE cycle inclusive.
- done  out  1  one-cycle pulse; result valid.
- mem_addr  out  ADDR_W  shared read address for input and weight memories.
- x_data  in  4  input-memory read data, valid 1 cycle after mem_addr.
- w_data  in  4  weight-memory read data, valid 1 cycle after mem_addr.
- mul_x  out  4  multiplier operand x; wired straight from x_data.
- mul_y  out  4  multiplier operand y; wired straight from w_data.
- mul_p  in  4  combinational Q2.2 product from the multiplier.
- acc  out  ACC_W  raw signed accumulator.
- result  out  4  ReLU+saturated Q2.2 neuron output.

## Operation
- Reset values: state=IDLE; busy=0; done=0; mem_addr=0; acc=0; internal read-valid flag=0; result=0.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE
  - busy=0.
  - On start=1: acc ← sign-extend(bias), mem_addr ← 0, next state RUN.
- RUN
  - mem_addr increments by 1 each cycle.
  - The cycle in which mem_addr = N_INPUTS-1 is the last RUN cycle; next state DRAIN.
  - mem_addr stays at N_INPUTS-1 after that and does not wrap.
- Read-valid pipeline
  - The flag is set on each edge that leaves a RUN cycle.
  - When the flag is 1, acc ← acc + sign-extend(mul_p), i.e. the product of the pair addressed in the previous cycle.
- DRAIN: accumulates the final product; next state DONE.
- DONE
  - done=1 for exactly one cycle; busy=1.
  - Next state IDLE unconditionally. start is ignored in this cycle.
- result
  - Combinational from acc.
  - acc<0 → 4'b0000.
  - acc>7 → 4'b0111.
  - Otherwise acc[3:0].
- acc and result hold their values in IDLE until the next start is accepted.
- start while busy=1: ignored, no queuing.
- start held high continuously: the next run is accepted in the IDLE cycle that follows DONE.
- rst mid-operation: all state returns to reset values immediately. Any in-flight computation is discarded; done is not asserted.
- N_INPUTS=1: RUN lasts one cycle, then DRAIN, then DONE.

## Timing
- Edge E0 samples start in IDLE.
- Cycle k after E0 (k=1..N_INPUTS): RUN with mem_addr=k-1.
- Product of address j is added at edge E(j+2).
- Cycle N_INPUTS+1 is DRAIN.
- Cycle N_INPUTS+2 is DONE: done=1, final acc and result are valid.
- Total latency: start-accept to done = N_INPUTS+2 cycles. Earliest next accept is cycle N_INPUTS+3.
- The multiplier path is combinational. The critical path is x_data → multiplier → ACC_W adder → acc.

## Test plan
- All pairs x=0100, w=0100, bias=0000 (N=4) → acc=16 (4.0), result=0111 saturated. done is high only in cycle 6 after E0. mem_addr runs 0,1,2,3.
- x=0100, w alternating 0100/1100, bias=0000 (N=4) → acc=0, result=0000.
- All x=0100, w=1100, bias=0010 (N=4) → acc=-14, result=0000 (ReLU).
- bias=0001; pair 0 is x=0100, w=0010 (mul_p=0010); other pairs zero → acc=3, result=0011. Sweep N_INPUTS=1 with the same pair: done in cycle 3.
- start held high for three runs → done pulses spaced N+3 cycles apart. Pulses of start during busy create no extra run. acc re-seeds from bias each run.
- rst asserted while mem_addr=2 → busy=0, done=0, mem_addr=0, acc=0 without waiting for a clock edge. A subsequent start produces the same result as a clean run.

Source files
------------

// File: rtl/neuron_mac_seq_if.sv
// Handshake and datapath bundle between the neuron sequencer, its memories and the shared multiplier.
// slave is the sequencer side; master is the controller/memory/multiplier side.
interface neuron_mac_seq_if #(
    parameter int ADDR_W = 4,
    parameter int ACC_W  = 12
);
    logic              start;
    logic [3:0]        bias;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        x_data;
    logic [3:0]        w_data;
    logic [3:0]        mul_x;
    logic [3:0]        mul_y;
    logic [3:0]        mul_p;
    logic [ACC_W-1:0]  acc;
    logic [3:0]        result;

    modport master (
        output start, bias, x_data, w_data, mul_p,
        input  busy, done, mem_addr, mul_x, mul_y, acc, result
    );

    modport slave (
        input  start, bias, x_data, w_data, mul_p,
        output busy, done, mem_addr, mul_x, mul_y, acc, result
    );
endinterface

// File: rtl/neuron_mac_seq.sv
// Neuron MAC sequencer: bias + sum of N_INPUTS Q2.2 products, then ReLU and saturate; done N_INPUTS+2 cycles after accept.
// No backpressure: start is accepted only in IDLE, ignored while busy, never queued.
module neuron_mac_seq #(
    parameter int N_INPUTS = 16,
    parameter int ADDR_W   = 4,
    parameter int ACC_W    = 12
) (
    input  logic             i_clk,
    input  logic             i_rst,
    neuron_mac_seq_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_INPUTS - 1);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [ACC_W-1:0]  r_acc;
    logic              r_rd_vld;
    logic [ACC_W-1:0]  w_prod_ext;
    logic [ACC_W-1:0]  w_bias_ext;
    logic [3:0]        w_result;
    logic              w_accept;

    assign w_accept   = (r_state == S_IDLE) && bus.start;
    assign w_prod_ext = {{(ACC_W-4){bus.mul_p[3]}}, bus.mul_p};
    assign w_bias_ext = {{(ACC_W-4){bus.bias[3]}}, bus.bias};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next = S_RUN;
            S_RUN:   if (r_addr == LAST_ADDR) w_next = S_DRAIN;
            S_DRAIN: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // r_rd_vld marks that mul_p holds the product of the address presented last cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_addr   <= '0;
            r_acc    <= '0;
            r_rd_vld <= 1'b0;
        end else begin
            r_rd_vld <= (r_state == S_RUN);
            if (w_accept) begin
                r_acc  <= w_bias_ext;
                r_addr <= '0;
            end else if (r_rd_vld) begin
                r_acc <= r_acc + w_prod_ext;
            end
            if ((r_state == S_RUN) && (r_addr != LAST_ADDR)) begin
                r_addr <= r_addr + ADDR_W'(1);
            end
        end
    end

    always_comb begin
        w_result = r_acc[3:0];
        if (r_acc[ACC_W-1]) begin
            w_result = 4'b0000;
        end else if (|r_acc[ACC_W-2:3]) begin
            w_result = 4'b0111;
        end
    end

    assign bus.busy     = (r_state != S_IDLE);
    assign bus.done     = (r_state == S_DONE);
    assign bus.mem_addr = r_addr;
    assign bus.mul_x    = bus.x_data;
    assign bus.mul_y    = bus.w_data;
    assign bus.acc      = r_acc;
    assign bus.result   = w_result;
endmodule

// File: tb/tb_neuron_mac_seq.sv
// Randomized and directed bench for neuron_mac_seq against an arithmetic reference model.
// Two instances: N_INPUTS=4 for the main runs and N_INPUTS=1 for the single-pair sweep.
module tb_neuron_mac_seq;
    localparam int N     = 4;
    localparam int ACC_W = 12;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_bad;
    logic [3:0] xmem [16];
    logic [3:0] wmem [16];

    neuron_mac_seq_if #(.ADDR_W(4), .ACC_W(ACC_W)) bus  ();
    neuron_mac_seq_if #(.ADDR_W(4), .ACC_W(ACC_W)) bus1 ();

    neuron_mac_seq #(.N_INPUTS(N), .ADDR_W(4), .ACC_W(ACC_W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    neuron_mac_seq #(.N_INPUTS(1), .ADDR_W(4), .ACC_W(ACC_W)) dut1 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External Q2.2 multiplier and synchronous-read memories around each DUT.
    function automatic logic [3:0] qmul(input logic [3:0] a, input logic [3:0] b);
        logic signed [7:0] p;
        p = $signed(a) * $signed(b);
        return p[5:2];
    endfunction

    assign bus.mul_p  = qmul(bus.mul_x, bus.mul_y);
    assign bus1.mul_p = qmul(bus1.mul_x, bus1.mul_y);

    always @(posedge clk) begin
        bus.x_data  <= xmem[bus.mem_addr];
        bus.w_data  <= wmem[bus.mem_addr];
        bus1.x_data <= xmem[bus1.mem_addr];
        bus1.w_data <= wmem[bus1.mem_addr];
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_acc(input logic [3:0] b, input int n);
        int s;
        int p;
        s = int'($signed(b));
        for (int i = 0; i < n; i++) begin
            p = int'($signed(xmem[i])) * int'($signed(wmem[i]));
            p = p >>> 2;
            p = ((p % 16) + 16) % 16;
            if (p > 7) p -= 16;
            s += p;
        end
        return s;
    endfunction

    function automatic int ref_res(input int a);
        if (a < 0) return 0;
        if (a > 7) return 7;
        return a;
    endfunction

    // One run on the N=4 instance; optionally toggles start while busy.
    task automatic do_run(input logic [3:0] b, input bit pulse, input string tag);
        int done_cyc;
        int exp_acc;
        @(negedge clk);
        bus.start = 1'b1;
        bus.bias  = b;
        @(posedge clk);
        #1 bus.start = 1'b0;
        done_cyc = -1;
        for (int k = 1; k <= N + 6 && done_cyc < 0; k++) begin
            @(negedge clk);
            if (k <= N) chk({tag, "_addr"}, int'(bus.mem_addr), k - 1);
            if (k == 1) chk({tag, "_busy"}, int'(bus.busy), 1);
            if (bus.done) done_cyc = k;
            bus.start = (pulse && k < N + 1) ? k[0] : 1'b0;
        end
        bus.start = 1'b0;
        exp_acc = ref_acc(b, N);
        chk({tag, "_done_cyc"}, done_cyc, N + 2);
        chk({tag, "_acc"}, int'($signed(bus.acc)), exp_acc);
        chk({tag, "_result"}, int'(bus.result), ref_res(exp_acc));
        @(negedge clk);
        chk({tag, "_idle_after"}, int'(bus.busy) + int'(bus.done), 0);
        chk({tag, "_acc_hold"}, int'($signed(bus.acc)), exp_acc);
    endtask

    task automatic fill(input logic [3:0] xv, input logic [3:0] w0, input logic [3:0] w1);
        for (int i = 0; i < 16; i++) begin
            xmem[i] = xv;
            wmem[i] = i[0] ? w1 : w0;
        end
    endtask

    initial begin
        int dc [3];
        int nd;
        int done1;
        logic [3:0] b;
        n_chk = 0;
        n_bad = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.bias = 4'd0;
        bus1.start = 1'b0;
        bus1.bias = 4'd0;
        fill(4'd0, 4'd0, 4'd0);
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_addr", int'(bus.mem_addr), 0);
        chk("rst_acc", int'(bus.acc), 0);
        chk("rst_result", int'(bus.result), 0);
        rst = 1'b0;

        fill(4'b0100, 4'b0100, 4'b0100);
        do_run(4'b0000, 1'b0, "sat");
        chk("sat_acc_lit", int'($signed(bus.acc)), 16);
        fill(4'b0100, 4'b0100, 4'b1100);
        do_run(4'b0000, 1'b0, "alt");
        fill(4'b0100, 4'b1100, 4'b1100);
        do_run(4'b0010, 1'b0, "relu");
        chk("relu_acc_lit", int'($signed(bus.acc)), -14);
        fill(4'b0000, 4'b0000, 4'b0000);
        xmem[0] = 4'b0100;
        wmem[0] = 4'b0010;
        do_run(4'b0001, 1'b0, "one");
        chk("one_result_lit", int'(bus.result), 3);

        @(negedge clk);
        bus1.start = 1'b1;
        bus1.bias  = 4'b0001;
        @(posedge clk);
        #1 bus1.start = 1'b0;
        done1 = -1;
        for (int k = 1; k <= 8 && done1 < 0; k++) begin
            @(negedge clk);
            if (bus1.done) done1 = k;
        end
        chk("n1_done_cyc", done1, 3);
        chk("n1_acc", int'($signed(bus1.acc)), ref_acc(4'b0001, 1));

        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < 16; i++) begin
                xmem[i] = 4'($urandom_range(0, 15));
                wmem[i] = 4'($urandom_range(0, 15));
            end
            b = 4'($urandom_range(0, 15));
            do_run(b, r[0], $sformatf("rnd%0d", r));
        end

        fill(4'b0100, 4'b0010, 4'b1110);
        xmem[2] = 4'b1000;
        @(negedge clk);
        bus.bias  = 4'b0011;
        bus.start = 1'b1;
        nd = 0;
        dc = '{0, 0, 0};
        for (int k = 1; k <= 40 && nd < 3; k++) begin
            @(negedge clk);
            if (bus.done) begin
                dc[nd] = k;
                chk($sformatf("held_acc%0d", nd), int'($signed(bus.acc)), ref_acc(4'b0011, N));
                nd++;
                if (nd == 3) bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        chk("held_count", nd, 3);
        chk("held_first", dc[0], N + 2);
        chk("held_gap1", dc[1] - dc[0], N + 3);
        chk("held_gap2", dc[2] - dc[1], N + 3);
        repeat (2) @(negedge clk);
        chk("held_stop", int'(bus.busy), 0);

        fill(4'b0100, 4'b0100, 4'b0011);
        @(negedge clk);
        bus.start = 1'b1;
        bus.bias  = 4'b1111;
        @(posedge clk);
        #1 bus.start = 1'b0;
        nd = 0;
        for (int k = 1; k <= 10 && nd == 0; k++) begin
            @(negedge clk);
            if (bus.mem_addr == 4'd2) nd = 1;
        end
        chk("mid_reach", nd, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_busy", int'(bus.busy), 0);
        chk("mid_done", int'(bus.done), 0);
        chk("mid_addr", int'(bus.mem_addr), 0);
        chk("mid_acc", int'(bus.acc), 0);
        @(negedge clk);
        rst = 1'b0;
        do_run(4'b1111, 1'b0, "post_rst");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
